text_glyph_blitter: RTL and testbench

TEXT_GLYPH_BLITTER -- requirements
Module: text_glyph_blitter

---
 rtl/text_glyph_blitter.sv | 106 ++++++++++
 tb/tb_text_glyph_blitter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/text_glyph_blitter.sv
// text_glyph_blitter: renders a 32x8 character buffer as 8x8 glyphs into a 640x480 colour-index memory.
module text_glyph_blitter #(
  parameter int unsigned ORIGIN_X = 0,
  parameter int unsigned ORIGIN_Y = 0,
  parameter logic [2:0]  FG_INDEX = 3'd1,
  parameter logic [2:0]  BG_INDEX = 3'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  char_addr,
  input  logic [7:0]  char_data,
  output logic [9:0]  font_addr,
  input  logic [7:0]  font_data,
  output logic [18:0] mem_waddr,
  output logic [2:0]  mem_wdata,
  output logic        mem_wenable,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, CHAR_RD, CHAR_WAIT, FONT_RD, FONT_WAIT, WRITE, DONE} state_t;
  state_t      state_q, state_d;
  logic [7:0]  char_q, char_d, code_q, code_d, row_q, row_d;
  logic [2:0]  grow_q, grow_d, px_q, px_d, wdata_q, wdata_d;
  logic [18:0] waddr_q, waddr_d, y_w, x_w;
  logic        wen_q, wen_d, busy_q, busy_d, done_q, done_d;
  always_comb begin
    state_d = state_q;
    char_d  = char_q;
    grow_d  = grow_q;
    px_d    = px_q;
    code_d  = code_q;
    row_d   = row_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = CHAR_RD;
        char_d  = '0;
        grow_d  = '0;
      end
      CHAR_RD:   state_d = CHAR_WAIT;
      CHAR_WAIT: begin
        code_d  = char_data;
        state_d = FONT_RD;
      end
      FONT_RD:   state_d = FONT_WAIT;
      FONT_WAIT: begin
        row_d   = font_data;
        px_d    = '0;
        state_d = WRITE;
      end
      WRITE:
        if (px_q != 3'd7) px_d = px_q + 3'd1;
        else if (grow_q != 3'd7) begin
          grow_d  = grow_q + 3'd1;
          state_d = FONT_RD;
        end else if (char_q == 8'd255) state_d = DONE;
        else begin
          char_d  = char_q + 8'd1;
          grow_d  = '0;
          state_d = CHAR_RD;
        end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from next-state values so they line up with the state they describe
    y_w     = 19'(ORIGIN_Y) + {13'd0, char_d[7:5], 3'd0} + {16'd0, grow_d};
    x_w     = 19'(ORIGIN_X) + {11'd0, char_d[4:0], 3'd0} + {16'd0, px_d};
    wen_d   = state_d == WRITE;
    busy_d  = (state_d != IDLE) && (state_d != DONE);
    done_d  = state_d == DONE;
    waddr_d = wen_d ? y_w * 19'd640 + x_w : waddr_q;
    wdata_d = wen_d ? ((row_d[3'd7 - px_d] ^ code_d[7]) ? FG_INDEX : BG_INDEX) : wdata_q;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      char_q  <= '0;
      grow_q  <= '0;
      px_q    <= '0;
      code_q  <= '0;
      row_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      char_q  <= char_d;
      grow_q  <= grow_d;
      px_q    <= px_d;
      code_q  <= code_d;
      row_q   <= row_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  assign char_addr   = char_q;
  assign font_addr   = {code_q[6:0], grow_q};
  assign mem_waddr   = waddr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wenable = wen_q;
  assign busy        = busy_q;
  assign done        = done_q;
endmodule

// File: tb/tb_text_glyph_blitter.sv
// tb_text_glyph_blitter: directed checks of reset, glyph rendering, inverse video, full pass and mid-pass reset.
module tb_text_glyph_blitter;
  logic        clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [7:0]  char_addr, char_data, font_data;
  logic [9:0]  font_addr;
  logic [18:0] mem_waddr;
  logic [2:0]  mem_wdata;
  logic        mem_wenable, busy, done;
  logic [7:0]  cbuf [256];
  logic [7:0]  font [1024];
  logic [18:0] cap_a [8];
  logic [2:0]  cap_d [8];
  logic [9:0]  cap_fa;
  bit          cap_to;
  int          total = 0, bad = 0;

  text_glyph_blitter dut (
    .clock(clock), .reset(reset), .start(start),
    .char_addr(char_addr), .char_data(char_data),
    .font_addr(font_addr), .font_data(font_data),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wenable(mem_wenable),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) char_data <= cbuf[char_addr];
  always @(posedge clock) font_data <= font[font_addr];

  task automatic do_reset();
    @(negedge clock); reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic capture8();
    int k;
    k = 0;
    cap_fa = '0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    for (int n = 0; n < 200 && k < 8; n++) begin
      if (n > 0) @(negedge clock);
      if (mem_wenable) begin
        if (k == 0) cap_fa = font_addr;
        cap_a[k] = mem_waddr;
        cap_d[k] = mem_wdata;
        k++;
      end
    end
    cap_to = k < 8;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1;
    repeat (3) @(negedge clock);
    total++; if ({char_addr, font_addr, mem_waddr, mem_wdata} !== 40'd0) begin bad++; $display("FAIL reset_addrs got=%0h want=0", {char_addr, font_addr, mem_waddr, mem_wdata}); end
    total++; if ({mem_wenable, busy, done} !== 3'b000) begin bad++; $display("FAIL reset_ctrl got=%b want=000", {mem_wenable, busy, done}); end
    start = 1'b0; reset = 1'b0;
    repeat (10) @(negedge clock);
    total++; if ({mem_wenable, busy, done} !== 3'b000) begin bad++; $display("FAIL reset_idle got=%b want=000", {mem_wenable, busy, done}); end
  endtask

  task automatic test_single_glyph();
    logic [7:0] pat;
    pat = 8'h18;
    cbuf[0] = 8'h41;
    capture8();
    total++; if (cap_to !== 1'b0) begin bad++; $display("FAIL glyph_timeout got=%b want=0", cap_to); end
    for (int i = 0; i < 8; i++) begin
      total++; if (cap_a[i] !== 19'(i)) begin bad++; $display("FAIL glyph_addr%0d got=%0d want=%0d", i, cap_a[i], i); end
      total++; if (cap_d[i] !== {2'b00, pat[7-i]}) begin bad++; $display("FAIL glyph_data%0d got=%0d want=%0d", i, cap_d[i], pat[7-i]); end
    end
    total++; if (cap_fa !== 10'h208) begin bad++; $display("FAIL glyph_font_addr got=%0h want=208", cap_fa); end
    do_reset();
  endtask

  task automatic test_inverse();
    logic [7:0] pat;
    pat = 8'he7;
    cbuf[0] = 8'hc1;
    capture8();
    total++; if (cap_to !== 1'b0) begin bad++; $display("FAIL inv_timeout got=%b want=0", cap_to); end
    for (int i = 0; i < 8; i++) begin
      total++; if (cap_d[i] !== {2'b00, pat[7-i]}) begin bad++; $display("FAIL inv_data%0d got=%0d want=%0d", i, cap_d[i], pat[7-i]); end
    end
    total++; if (cap_fa[9:3] !== 7'h41) begin bad++; $display("FAIL inv_font_code got=%0h want=41", cap_fa[9:3]); end
    cbuf[0] = 8'h20;
    do_reset();
  endtask

  task automatic test_full_pass();
    int writes, dones, done_n, err_k, stray;
    logic [18:0] last_a, ea;
    logic [2:0] ed;
    logic busy0, busy_pre, busy_end;
    int c, g, p;
    writes = 0; dones = 0; done_n = -1; err_k = -1; stray = 0; last_a = '0;
    busy0 = 1'b0; busy_pre = 1'b0; busy_end = 1'b1;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    for (int n = 0; n < 21100; n++) begin
      if (n > 0) @(negedge clock);
      if (mem_wenable) begin
        c = writes / 64; g = (writes / 8) % 8; p = writes % 8;
        ea = 19'((((c / 32) * 8 + g) * 640) + (c % 32) * 8 + p);
        ed = (p == 7 - g) ? 3'd1 : 3'd0;
        if (err_k < 0 && (mem_waddr !== ea || mem_wdata !== ed || n != c * 82 + g * 10 + p + 4)) err_k = writes;
        last_a = mem_waddr;
        writes++;
      end
      if (done) begin dones++; done_n = n; end
      if (n == 0) busy0 = busy;
      if (n == 20991) busy_pre = busy;
      if (n == 20992) busy_end = busy;
      if (n > 21000 && (busy || mem_wenable)) stray++;
      start = (n == 100 || n == 20991 || n == 20992);
    end
    start = 1'b0;
    total++; if (writes !== 16384) begin bad++; $display("FAIL full_writes got=%0d want=16384", writes); end
    total++; if (err_k !== -1) begin bad++; $display("FAIL full_sequence first_bad_write=%0d want=none", err_k); end
    total++; if (last_a !== 19'd40575) begin bad++; $display("FAIL full_last_addr got=%0d want=40575", last_a); end
    total++; if (done_n !== 20992) begin bad++; $display("FAIL full_done_cycle got=%0d want=20992", done_n); end
    total++; if (dones !== 1) begin bad++; $display("FAIL full_done_count got=%0d want=1", dones); end
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL full_busy_start got=%b want=1", busy0); end
    total++; if ({busy_pre, busy_end} !== 2'b10) begin bad++; $display("FAIL full_busy_fall got=%b want=10", {busy_pre, busy_end}); end
    total++; if (stray !== 0) begin bad++; $display("FAIL full_after_done got=%0d want=0", stray); end
  endtask

  task automatic test_mid_reset();
    bit seen;
    seen = 1'b0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (2000) @(negedge clock);
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clock);
      seen = mem_wenable;
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL mid_write_seen got=%b want=1", seen); end
    reset = 1'b1;
    #1;
    total++; if ({mem_wenable, busy, done} !== 3'b000) begin bad++; $display("FAIL mid_reset_ctrl got=%b want=000", {mem_wenable, busy, done}); end
    @(negedge clock); reset = 1'b0;
    repeat (5) @(negedge clock);
    total++; if ({mem_wenable, busy} !== 2'b00) begin bad++; $display("FAIL mid_stays_idle got=%b want=00", {mem_wenable, busy}); end
    capture8();
    total++; if (cap_to !== 1'b0) begin bad++; $display("FAIL mid_timeout got=%b want=0", cap_to); end
    for (int i = 0; i < 8; i++) begin
      total++; if (cap_a[i] !== 19'(i) || cap_d[i] !== ((i == 7) ? 3'd1 : 3'd0)) begin bad++; $display("FAIL mid_restart%0d got=%0d/%0d want=%0d/%0d", i, cap_a[i], cap_d[i], i, (i == 7) ? 1 : 0); end
    end
    do_reset();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) cbuf[i] = 8'h20;
    for (int i = 0; i < 1024; i++) font[i] = 8'h00;
    for (int g = 0; g < 8; g++) font[256 + g] = 8'(1 << g);
    font[10'h208] = 8'h18;
    test_reset();
    test_single_glyph();
    test_inverse();
    test_full_pass();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
